// File: rtl/spi_slave_rx.sv
// Receive-only SPI slave: synchronizes SCLK/MOSI/SS_n, assembles MSB-first words in any CPOL/CPHA
// mode and buffers them in a show-ahead FIFO presented on a valid/ready interface.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  input  logic              cpol,
  input  logic              cpha,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              frame_err,
  output logic              busy,
  output logic              fsm_state_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Consumer side: a pop happens when rx_valid && rx_ready at a rising clock edge;
  // rx_data is the head word whenever rx_valid is high and does not depend on rx_ready.

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   prev_sclk_q;
  logic                   sclk_s, mosi_s, ss_s;

  // sclk chain resets to the idle level so no phantom edge appears after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      prev_sclk_q <= cpol;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      prev_sclk_q <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];

  state_t            state_q;
  logic              mode_cpol_q, mode_cpha_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              busy_q, frame_err_q;
  logic              rise, fall, sample_edge, word_done;

  assign rise        = sclk_s & ~prev_sclk_q;
  assign fall        = ~sclk_s & prev_sclk_q;
  assign sample_edge = (mode_cpol_q == mode_cpha_q) ? rise : fall;
  assign shreg_d     = {shreg_q[DATA_W-2:0], mosi_s};
  // SS rising wins over a coincident sample edge, so the word never completes in that cycle.
  assign word_done   = (state_q == SHIFT) && !ss_s && sample_edge &&
                       (bit_cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_cpol_q <= 1'b0;
      mode_cpha_q <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!ss_s) begin
            state_q     <= SHIFT;
            mode_cpol_q <= cpol;
            mode_cpha_q <= cpha;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b1;
          end
        end
        SHIFT: begin
          if (ss_s) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            frame_err_q <= (bit_cnt_q != '0);
            bit_cnt_q   <= '0;
          end else if (sample_edge) begin
            shreg_q <= shreg_d;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  count_q;
  logic              overflow_q;
  logic              pop, full, push_ok, drop;

  assign pop     = rx_valid && rx_ready;
  assign full    = (count_q == OCC_W'(FIFO_DEPTH));
  // When full, a same-cycle pop frees the slot the new word lands in.
  assign push_ok = word_done && (!full || pop);
  assign drop    = word_done && full && !pop;

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shreg_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + OCC_W'(1);
        2'b01:   count_q <= count_q - OCC_W'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign rx_valid    = (count_q != '0);
  assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: an SPI master driver feeds a word-level model (queue FIFO, 3-clock pin
// latency) that is compared against the DUT outputs on every falling clock edge.
module tb_spi_slave_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int H     = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1, cpol = 1'b0, cpha = 1'b0;
  logic rx_ready = 1'b0, clr_overflow = 1'b0;
  logic [DW-1:0] rx_data;
  logic rx_valid, overflow, frame_err, busy, fsm_state;

  always #5 clock = ~clock;

  spi_slave_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .cpol(cpol), .cpha(cpha), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .overflow(overflow), .clr_overflow(clr_overflow),
    .frame_err(frame_err), .busy(busy), .fsm_state_o(fsm_state)
  );

  int checks = 0, errors = 0, cyc = 0, ferr_seen = 0;

  // Model events: 0 = word completed, 1 = ss fell, 2 = ss rose (data[0] = partial word pending).
  typedef struct {
    int            due;
    int            kind;
    logic [DW-1:0] data;
  } ev_t;
  ev_t           ev_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  bit            m_ovf, m_busy, m_ferr;
  logic [DW-1:0] acc;
  int            nb;
  int            pop_due = -1;
  bit            arm_pop = 0, rdy_base = 0, rdy_rand = 0, clr_req = 0, clr_rand = 0;
  logic [DW-1:0] tx_w[16];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    ev_q.delete();
    m_ovf = 0; m_busy = 0; m_ferr = 0;
    nb = 0; acc = '0; pop_due = -1;
  endfunction

  // Every pin event becomes visible at the third rising clock edge after it.
  function automatic void sched(input int kind, input logic [DW-1:0] d);
    ev_t e;
    e.due = cyc + 3; e.kind = kind; e.data = d;
    ev_q.push_back(e);
  endfunction

  always @(posedge clock) begin
    bit pop, push, ovf_set;
    logic [DW-1:0] pw;
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      pop = rx_ready && (exp_q.size() != 0);
      push = 0; ovf_set = 0; pw = '0;
      m_ferr = 0;
      for (int i = 0; i < ev_q.size(); ) begin
        if (ev_q[i].due == cyc) begin
          case (ev_q[i].kind)
            0: begin push = 1; pw = ev_q[i].data; end
            1: m_busy = 1;
            default: begin m_busy = 0; m_ferr = ev_q[i].data[0]; end
          endcase
          ev_q.delete(i);
        end else begin
          i++;
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(pw);
        else ovf_set = 1;
      end
      if (ovf_set) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
  end

  always @(posedge clock) begin
    #1;
    rx_ready     = (cyc + 1 == pop_due) || (rdy_rand ? ($urandom_range(0, 2) == 0) : rdy_base);
    clr_overflow = clr_req || (clr_rand && ($urandom_range(0, 31) == 0));
  end

  always @(negedge clock) begin
    chk("rx_valid", rx_valid, exp_q.size() != 0);
    chk("rx_data", rx_data, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_busy);
    chk("fsm_state", fsm_state, m_busy);
    chk("frame_err", frame_err, m_ferr);
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_seen++;
  end

  task automatic clk(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // The model records mosi on whichever edge the DUT's configured mode samples.
  task automatic set_sclk(input logic v);
    sclk = v;
    if (v == (cpol == cpha)) begin
      acc = {acc[DW-2:0], mosi};
      nb++;
      if (nb == DW) begin
        sched(0, acc);
        if (arm_pop) begin pop_due = cyc + 3; arm_pop = 0; end
        nb = 0;
      end
    end
  endtask

  task automatic start_frame(input int drv_mode, input int dut_mode);
    cpol = dut_mode[1]; cpha = dut_mode[0];
    sclk = drv_mode[1]; mosi = 1'b0; nb = 0;
    clk(6);
    ss_n = 1'b0;
    sched(1, '0);
    clk(6);
  endtask

  task automatic send_bit(input int drv_mode, input logic b);
    logic idle;
    idle = drv_mode[1];
    if (drv_mode[0] == 0) begin
      clk(1); mosi = b; clk(H - 1);
      set_sclk(~idle); clk(H);
      set_sclk(idle);
    end else begin
      set_sclk(~idle); clk(1); mosi = b; clk(H - 1);
      set_sclk(idle); clk(H);
    end
  endtask

  task automatic end_frame();
    clk(H);
    ss_n = 1'b1;
    sched(2, DW'(nb != 0));
    nb = 0;
    clk(8);
  endtask

  task automatic send_frame(input int drv_mode, input int dut_mode, input int nbits);
    logic [DW-1:0] w;
    start_frame(drv_mode, dut_mode);
    for (int i = 0; i < nbits; i++) begin
      w = tx_w[i / DW];
      send_bit(drv_mode, w[DW - 1 - (i % DW)]);
    end
    end_frame();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_data"}, rx_data, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] w;
    int m, nw, part;
    model_clear();
    clk(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    clk(4);

    rdy_base = 1; got_q.delete(); ferr_seen = 0;
    tx_w[0] = 8'hA5; tx_w[1] = 8'h3C;
    send_frame(0, 0, 16);
    clk(4);
    chk("m0_count", got_q.size(), 2);
    chk("m0_word0", got_at(0), 8'hA5);
    chk("m0_word1", got_at(1), 8'h3C);
    chk("m0_ferr", ferr_seen, 0);

    for (int md = 1; md < 4; md++) begin
      got_q.delete();
      tx_w[0] = 8'h96;
      send_frame(md, md, 8);
      clk(4);
      chk("mode_count", got_q.size(), 1);
      chk("mode_word", got_at(0), 8'h96);
    end

    got_q.delete();
    send_frame(1, 0, 8);
    clk(4);
    chk("wrong_mode_word", got_at(0), 8'h4B);

    rdy_base = 0; got_q.delete();
    tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33; tx_w[3] = 8'h44; tx_w[4] = 8'h55;
    send_frame(0, 0, 40);
    chk("ovf_set", overflow, 1);
    chk("ovf_valid", rx_valid, 1);
    rdy_base = 1;
    clk(10);
    chk("ovf_count", got_q.size(), 4);
    chk("ovf_w0", got_at(0), 8'h11);
    chk("ovf_w3", got_at(3), 8'h44);
    clr_req = 1; clk(2); clr_req = 0; clk(2);
    chk("ovf_clear", overflow, 0);

    ferr_seen = 0; got_q.delete();
    tx_w[0] = 8'hE7;
    send_frame(0, 0, 3);
    chk("ferr_pulses", ferr_seen, 1);
    chk("ferr_nopush", got_q.size(), 0);
    chk("ferr_busy", busy, 0);

    rdy_base = 0; got_q.delete();
    tx_w[0] = 8'h01; tx_w[1] = 8'h02; tx_w[2] = 8'h03; tx_w[3] = 8'h04; tx_w[4] = 8'h5C;
    start_frame(3, 3);
    for (int i = 0; i < 40; i++) begin
      if (i == 32) arm_pop = 1;
      w = tx_w[i / DW];
      send_bit(3, w[DW - 1 - (i % DW)]);
    end
    end_frame();
    chk("fullpop_ovf", overflow, 0);
    rdy_base = 1;
    clk(10);
    chk("fullpop_count", got_q.size(), 5);
    chk("fullpop_last", got_at(4), 8'h5C);

    got_q.delete();
    start_frame(0, 0);
    send_bit(0, 1'b1); send_bit(0, 1'b0); send_bit(0, 1'b1);
    reset = 1'b1;
    model_clear();
    ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    clk(1);
    check_idle_outputs("midreset");
    clk(3);
    reset = 1'b0;
    clk(4);
    ferr_seen = 0;
    tx_w[0] = 8'h5A;
    send_frame(0, 0, 8);
    clk(4);
    chk("post_reset_count", got_q.size(), 1);
    chk("post_reset_word", got_at(0), 8'h5A);
    chk("post_reset_ferr", ferr_seen, 0);

    rdy_rand = 1; clr_rand = 1;
    for (int f = 0; f < 25; f++) begin
      m = $urandom_range(0, 3);
      nw = $urandom_range(1, 3);
      part = ($urandom_range(0, 4) == 0) ? $urandom_range(1, DW - 1) : 0;
      for (int k = 0; k < nw + 1; k++) tx_w[k] = DW'($urandom_range(0, 255));
      send_frame(m, m, nw * DW + part);
    end
    rdy_rand = 0; clr_rand = 0; rdy_base = 1;
    clk(20);
    chk("drain_valid", rx_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
